// File: rtl/acc_dispense.sv
// Splits a 16-bit total into valid/ready beats of at most MAX_STEP each.
// Optional beat counter output o_count is enabled by defining ACC_DISPENSE_CNT_EN.
module acc_dispense #(
    parameter int unsigned MAX_STEP = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic [15:0] i_total,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [7:0]  o_out,
    output logic        o_last,
    output logic        o_busy,
    output logic        o_done,
`ifdef ACC_DISPENSE_CNT_EN
    output logic [15:0] o_count,
`endif
    output logic [15:0] o_remain
);

    localparam logic [15:0] MAX16 = 16'(MAX_STEP);
    localparam logic [7:0]  MAX8  = 8'(MAX_STEP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      nxt_state;
    logic [15:0] remain;
    logic [15:0] nxt_remain;
    logic        load_acc;
    logic        xfer;

    function automatic logic [7:0] beat_of(input logic [15:0] r);
        return (r > MAX16) ? MAX8 : r[7:0];
    endfunction

    assign load_acc = (state == IDLE) && i_load;
    assign xfer     = (state == RUN) && i_ready;

    // o_out/o_last already hold the beat for the current remain, so they drive the transfer.
    always_comb begin
        nxt_state  = state;
        nxt_remain = remain;
        case (state)
            IDLE: begin
                if (i_load) begin
                    nxt_remain = i_total;
                    nxt_state  = (i_total != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (i_ready) begin
                    nxt_remain = remain - {8'h00, o_out};
                    if (o_last) begin
                        nxt_state = DONE;
                    end
                end
            end
            DONE: begin
                nxt_state = IDLE;
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they carry no input paths.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            remain   <= '0;
            o_valid  <= 1'b0;
            o_out    <= '0;
            o_last   <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_remain <= '0;
        end else begin
            state    <= nxt_state;
            remain   <= nxt_remain;
            o_valid  <= (nxt_state == RUN);
            o_out    <= (nxt_state == RUN) ? beat_of(nxt_remain) : '0;
            o_last   <= (nxt_state == RUN) && (nxt_remain <= MAX16);
            o_busy   <= (nxt_state != IDLE);
            o_done   <= (nxt_state == DONE);
            o_remain <= nxt_remain;
        end
    end

`ifdef ACC_DISPENSE_CNT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst || load_acc) begin
            o_count <= '0;
        end else if (xfer) begin
            o_count <= o_count + 16'd1;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = load_acc ^ xfer;
`endif

endmodule

// File: tb/tb_acc_dispense.sv
// Randomized scoreboard bench for acc_dispense; a second instance covers MAX_STEP=1.
module tb_acc_dispense;

    localparam int MAXS = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_load;
    logic [15:0] i_total;
    logic        i_ready;
    logic        o_valid, o_last, o_busy, o_done;
    logic [7:0]  o_out;
    logic [15:0] o_remain;

    logic        ld1;
    logic [15:0] tot1;
    logic        rdy1;
    logic        v1, last1, busy1, done1;
    logic [7:0]  out1;
    logic [15:0] rem1;

`ifdef ACC_DISPENSE_CNT_EN
    logic [15:0] o_count;
    logic [15:0] count1;
`endif

    always #5 clk = ~clk;

    acc_dispense #(.MAX_STEP(MAXS)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_load(i_load), .i_total(i_total), .i_ready(i_ready),
        .o_valid(o_valid), .o_out(o_out), .o_last(o_last), .o_busy(o_busy), .o_done(o_done),
`ifdef ACC_DISPENSE_CNT_EN
        .o_count(o_count),
`endif
        .o_remain(o_remain)
    );

    acc_dispense #(.MAX_STEP(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_load(ld1), .i_total(tot1), .i_ready(rdy1),
        .o_valid(v1), .o_out(out1), .o_last(last1), .o_busy(busy1), .o_done(done1),
`ifdef ACC_DISPENSE_CNT_EN
        .o_count(count1),
`endif
        .o_remain(rem1)
    );

    typedef struct {
        int beat;
        bit last;
        int remain;
    } beat_t;

    beat_t beat_q[$];
    int    done_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: greedy split of the total into MAX-sized beats, remainder last.
    task automatic model_push(input int total, input int maxs);
        int r = total;
        int n = 0;
        while (r > 0) begin
            beat_t b;
            b.beat   = (r > maxs) ? maxs : r;
            b.last   = (r <= maxs);
            b.remain = r;
            beat_q.push_back(b);
            r -= b.beat;
            n++;
        end
        done_q.push_back(n);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (o_valid) begin
                if (beat_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    check("beat_out", int'(o_out), beat_q[0].beat);
                    check("beat_last", int'(o_last), int'(beat_q[0].last));
                    check("beat_remain", int'(o_remain), beat_q[0].remain);
                    if (i_ready) void'(beat_q.pop_front());
                end
            end else begin
                check("idle_out_zero", int'(o_out), 0);
                check("idle_last_zero", int'(o_last), 0);
            end
            if (o_done) begin
                check("done_beats_consumed", beat_q.size(), 0);
                if (done_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    int n = done_q.pop_front();
`ifdef ACC_DISPENSE_CNT_EN
                    check("count_at_done", int'(o_count), n);
`else
                    if (n < 0) check("beat_count", n, 0);
`endif
                    check("done_busy", int'(o_busy), 1);
                end
            end
        end
    endtask

    task automatic do_load(input int total);
        i_load  = 1'b1;
        i_total = 16'(total);
        model_push(total, MAXS);
        @(posedge clk); #1;
        i_load  = 1'b0;
        i_total = 16'($urandom);
        check("load_latency", int'(o_valid || o_done), 1);
        check("load_busy", int'(o_busy), 1);
        if (total == 0) check("zero_no_valid", int'(o_valid), 0);
    endtask

    task automatic wait_idle(input bit rnd);
        int c = 0;
        while (o_busy && c < 5000) begin
            if (rnd) begin
                i_ready = ($urandom % 4) != 0;
                i_load  = ($urandom % 6) == 0;
                i_total = 16'($urandom);
            end
            @(posedge clk); #1;
            c++;
        end
        i_load = 1'b0;
        if (c >= 5000) check("idle_timeout", 1, 0);
    endtask

    initial begin
        rst = 1'b1; i_load = 1'b0; i_total = '0; i_ready = 1'b0;
        ld1 = 1'b0; tot1 = '0; rdy1 = 1'b1;
        fork
            monitor();
        join_none
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", int'(o_valid), 0);
        check("rst_out", int'(o_out), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_remain", int'(o_remain), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic 600 -> 255, 255, 90
        i_ready = 1'b1;
        do_load(600);
        wait_idle(0);

        // Zero total: single DONE cycle, busy only then
        do_load(0);
        @(posedge clk); #1;
        check("zero_busy_drop", int'(o_busy), 0);
        check("zero_done_drop", int'(o_done), 0);

        // Backpressure: held beat is re-checked every stalled cycle
        i_ready = 1'b0;
        do_load(300);
        repeat (3) @(posedge clk);
        #1;
        i_ready = 1'b1;
        wait_idle(0);

        // Load during RUN is ignored
        do_load(1000);
        i_load = 1'b1; i_total = 16'd5;
        @(posedge clk); #1;
        i_load = 1'b0;
        wait_idle(0);

        // Reset after first beat abandons the dispense
        do_load(600);
        @(posedge clk); #1;
        rst = 1'b1; i_ready = 1'b0;
        @(posedge clk); #1;
        beat_q.delete();
        done_q.delete();
        rst = 1'b0;
        check("midrst_valid", int'(o_valid), 0);
        check("midrst_busy", int'(o_busy), 0);
        check("midrst_done", int'(o_done), 0);
        check("midrst_remain", int'(o_remain), 0);
        repeat (2) @(posedge clk);
        #1;
        i_ready = 1'b1;
        do_load(10);
        wait_idle(0);

        // Largest total: 257 full beats
        do_load(65535);
        wait_idle(0);

        // Randomized totals with random backpressure and stray loads
        for (int t = 0; t < 25; t++) begin
            int tot;
            case ($urandom % 4)
                0: tot = $urandom % 4;
                1: tot = MAXS * int'($urandom_range(1, 4)) + int'($urandom_range(0, 2)) - 1;
                default: tot = $urandom % 2000;
            endcase
            i_ready = ($urandom % 2) != 0;
            do_load(tot);
            wait_idle(1);
            @(posedge clk); #1;
        end

        // MAX_STEP=1 instance: 3 -> 1, 1, 1
        ld1 = 1'b1; tot1 = 16'd3;
        @(posedge clk); #1;
        ld1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("m1_valid", int'(v1), 1);
            check("m1_out", int'(out1), 1);
            check("m1_last", int'(last1), int'(k == 2));
            check("m1_remain", int'(rem1), 3 - k);
            @(posedge clk); #1;
        end
        check("m1_done", int'(done1), 1);
`ifdef ACC_DISPENSE_CNT_EN
        check("m1_count", int'(count1), 3);
`endif
        @(posedge clk); #1;
        check("m1_idle", int'(busy1), 0);

        check("queue_drained", beat_q.size() + done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
